// File: rtl/oam_dma.sv
// Sprite-attribute DMA: a CPU write to REG_ADDR halts the CPU and copies page $XX00-$XXFF into OAM_ADDR.
// Define OAM_DMA_ALIGN_EN to insert a dummy ALIGN read so that every READ lands on a get (parity==0) cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | CPU owns the bus; a write to REG_ADDR latches the source page
// S_HALT  | cpu_rdy low, CPU still finishes its frozen cycle on the bus
// S_ALIGN | dummy read of {page,00} that puts the first READ on a get cycle
// S_READ  | read {page,idx} and capture bus_rdata
// S_WRITE | write the captured byte to OAM_ADDR, advance idx
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_latch;
  logic       r_done;
  logic       w_trig;
  logic       w_last;

  assign w_trig   = reg_we && (reg_addr == REG_ADDR);
  assign w_last   = (r_state == S_WRITE) && (r_idx == 8'hFF);
  assign dma_done = r_done;

`ifdef OAM_DMA_ALIGN_EN
  // Free-running from reset; 0 marks a get (read-legal) cycle.
  logic r_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_parity <= 1'b0;
    else       r_parity <= ~r_parity;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_idx   <= 8'h00;
      r_latch <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      if (r_state == S_IDLE && w_trig) begin
        r_page <= reg_wdata;
        r_idx  <= 8'h00;
      end
      if (r_state == S_READ)  r_latch <= bus_rdata;
      if (r_state == S_WRITE) r_idx   <= r_idx + 8'h01;
    end
  end

  always_comb begin
    w_next     = r_state;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    bus_addr   = 16'h0000;
    bus_rw     = 1'b1;
    bus_wdata  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_trig) w_next = S_HALT;
      end
      S_HALT: begin
        cpu_rdy = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
        w_next = r_parity ? S_READ : S_ALIGN;
`else
        w_next = S_READ;
`endif
      end
      S_ALIGN: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = {r_page, 8'h00};
        w_next     = S_READ;
      end
      S_READ: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = {r_page, r_idx};
        w_next     = S_WRITE;
      end
      S_WRITE: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_rw     = 1'b0;
        bus_addr   = OAM_ADDR;
        bus_wdata  = r_latch;
        w_next     = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: vector table, randomized transfers, mid-transfer reset and back-to-back triggers.
// Expected bus traffic is derived from the transfer rules (page list, stall length, get-cycle parity).
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_we = 1'b0;
  logic [15:0] reg_addr = 16'h0000;
  logic [7:0]  reg_wdata = 8'h00;
  logic        cpu_rdy, dma_active, bus_rw, dma_done;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  // Memory model: every byte reads back as its low address bits XOR 5A.
  assign bus_rdata = bus_addr[7:0] ^ 8'h5A;

  oam_dma dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .cpu_rdy(cpu_rdy), .dma_active(dma_active), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .dma_done(dma_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Clock count since reset release; its LSB is the parity of the current cycle.
  int unsigned cyc;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  int m_stall, m_act, m_done, m_wr, m_wrerr, m_idlebus, m_odd;
  logic [15:0] rd_q[$];
  logic [15:0] last_rd;

  int exp_stall, exp_act, exp_done, exp_wr, exp_odd;
  logic [15:0] exp_rd[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (!cpu_rdy)   m_stall++;
      if (dma_active) m_act++;
      if (dma_done)   m_done++;
      if (dma_active && bus_rw) begin
        rd_q.push_back(bus_addr);
        last_rd = bus_addr;
        if (cyc[0]) m_odd++;
      end
      if (dma_active && !bus_rw) begin
        m_wr++;
        if (bus_addr != 16'h2004 || bus_wdata != (last_rd[7:0] ^ 8'h5A)) m_wrerr++;
      end
      if (!dma_active && (bus_addr != 16'h0000 || !bus_rw || bus_wdata != 8'h00)) m_idlebus++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear();
    m_stall = 0; m_act = 0; m_done = 0; m_wr = 0; m_wrerr = 0; m_idlebus = 0; m_odd = 0;
    rd_q.delete();
    last_rd = 16'h0000;
    exp_stall = 0; exp_act = 0; exp_done = 0; exp_wr = 0; exp_odd = 0;
    exp_rd.delete();
  endtask

  // One DMA triggered in a cycle of parity p: HALT then has parity ~p, so align happens when p==1.
  task automatic add_dma(input logic [7:0] page, input bit p);
    bit al;
    al = ALIGN_EN && p;
    if (al) exp_rd.push_back({page, 8'h00});
    for (int i = 0; i < 256; i++) exp_rd.push_back({page, 8'(i)});
    exp_stall += 513 + int'(al);
    exp_act   += 512 + int'(al);
    exp_wr    += 256;
    exp_done  += 1;
    exp_odd   += al ? 1 : ((!ALIGN_EN && p) ? 256 : 0);
  endtask

  // Called at posedge+#1; drives a CPU cycle whose parity is par.
  task automatic drive_cpu(input bit we, input logic [15:0] addr, input logic [7:0] data,
                           input bit par, output bit p);
    if (cyc[0] != par) begin
      @(posedge clk); #1;
    end
    p = cyc[0];
    reg_we = we; reg_addr = addr; reg_wdata = data;
    @(posedge clk); #1;
    reg_we = 1'b0; reg_addr = 16'h0000; reg_wdata = 8'h00;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 1400 && m_done < n; k++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic verify(input string tag);
    int bad;
    int n;
    bad = 0;
    n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < n; i++) if (rd_q[i] != exp_rd[i]) bad++;
    check({tag, "_stall"},   m_stall, exp_stall);
    check({tag, "_active"},  m_act, exp_act);
    check({tag, "_nreads"},  rd_q.size(), exp_rd.size());
    check({tag, "_rdaddr"},  bad, 0);
    check({tag, "_nwrites"}, m_wr, exp_wr);
    check({tag, "_wrdata"},  m_wrerr, 0);
    check({tag, "_done"},    m_done, exp_done);
    check({tag, "_oddrd"},   m_odd, exp_odd);
    check({tag, "_idlebus"}, m_idlebus, 0);
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          par;
    bit          exp_trig;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit p, p2, found;
    vecs[0] = '{1'b1, 16'h4014, 8'h02, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 16'h4014, 8'h02, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 16'h4015, 8'h02, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h4014, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h2004, 8'h55, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h4014, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 16'h4014, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'h0014, 8'h02, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rdy", cpu_rdy, 1);
    check("rst_active", dma_active, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_rw", bus_rw, 1);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_done", dma_done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      clear();
      drive_cpu(vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].par, p);
      if (vecs[v].exp_trig) begin
        add_dma(vecs[v].data, p);
        wait_done(1);
      end else begin
        repeat (20) begin
          @(posedge clk); #1;
        end
      end
      verify($sformatf("vec%0d", v));
    end

    for (int r = 0; r < 4; r++) begin
      logic [15:0] a;
      logic [7:0] pg;
      clear();
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4016;
      drive_cpu(1'b1, a, 8'($urandom), 1'($urandom_range(0, 1)), p);
      pg = 8'($urandom_range(0, 255));
      drive_cpu(1'b1, 16'h4014, pg, 1'($urandom_range(0, 1)), p);
      add_dma(pg, p);
      wait_done(1);
      verify($sformatf("rnd%0d", r));
    end

    // Reset during the WRITE with idx==8'h40 (the 65th write).
    clear();
    drive_cpu(1'b1, 16'h4014, 8'h01, 1'b0, p);
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(posedge clk); #1;
      if (dma_active && !bus_rw && m_wr == 64) found = 1'b1;
    end
    check("mid_found", found, 1);
    reset = 1'b1;
    #1;
    check("mid_cpu_rdy", cpu_rdy, 1);
    check("mid_active", dma_active, 0);
    check("mid_bus_rw", bus_rw, 1);
    check("mid_done", dma_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear();
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("post_rst_done", m_done, 0);
    check("post_rst_stall", m_stall, 0);
    clear();
    drive_cpu(1'b1, 16'h4014, 8'h03, 1'($urandom_range(0, 1)), p);
    add_dma(8'h03, p);
    wait_done(1);
    verify("after_rst");

    // Retrigger in the cycle dma_done is high.
    clear();
    drive_cpu(1'b1, 16'h4014, 8'h02, 1'($urandom_range(0, 1)), p);
    add_dma(8'h02, p);
    found = 1'b0;
    for (int k = 0; k < 700 && !found; k++) begin
      @(posedge clk); #1;
      if (dma_done) found = 1'b1;
    end
    check("b2b_first_done", found, 1);
    p2 = cyc[0];
    reg_we = 1'b1; reg_addr = 16'h4014; reg_wdata = 8'h07;
    @(posedge clk); #1;
    reg_we = 1'b0; reg_addr = 16'h0000; reg_wdata = 8'h00;
    check("b2b_rdy_low", cpu_rdy, 0);
    add_dma(8'h07, p2);
    wait_done(2);
    verify("b2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
